dp1m4_row_ctrl: RTL and testbench

DP1M4_ROW_CTRL -- requirements
Module: dp1m4_row_ctrl

---
 rtl/dp1m4_pkg.sv | 26 ++
 rtl/dp1m4_beat_cnt.sv | 26 ++
 rtl/dp1m4_row_ctrl.sv | 159 +++++++++++++++
 tb/tb_dp1m4_row_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp1m4_pkg.sv
// Shared types and default constants for the dp1m4 row controller slice.
package dp1m4_pkg;

    localparam int COL_DEF     = 4;
    localparam int BW_DEF      = 4;
    localparam int PSUM_BW_DEF = 20;
    localparam int NNZ_DEF     = 8;
    localparam int TOTAL_DEF   = 16;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_EXEC   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    // Cycles the row pipeline needs to flush after its last activation.
    function automatic int drain_lat(input int c);
        return c + 1;
    endfunction

    localparam int DRAIN_LAT_DEF = COL_DEF + 1;

endpackage

// File: rtl/dp1m4_beat_cnt.sv
// Saturating up-counter with synchronous clear; at_term flags cnt == term.
module dp1m4_beat_cnt
    import dp1m4_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    assign at_term = (cnt == term);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && !at_term) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dp1m4_row_ctrl.sv
// Sequences weight load, activation streaming, drain and result handoff for one PE row.
// Optional DP1M4_CTRL_PERF_EN adds the stall_cnt performance output.
module dp1m4_row_ctrl
    import dp1m4_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int bw      = BW_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int nnz     = NNZ_DEF,
    parameter int total   = TOTAL_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_act,
    output logic                   busy,
    output logic                   done,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [nnz*bw-1:0]      w_data,
    input  logic [total-1:0]       w_mask,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [2*bw-1:0]        a_data,
    input  logic [3:0]             a_idx,
    output logic [nnz*bw-1:0]      row_weights_flat,
    output logic [total-1:0]       row_weight_mask,
    output logic [2*bw-1:0]        row_activation_flat,
    output logic [3:0]             row_activation_index_flat,
    output logic                   row_load,
    output logic                   row_execute,
    output logic                   row_a_select,
    input  logic [col*psum_bw-1:0] row_psum_flat,
    output logic                   res_valid,
    input  logic                   res_ready,
`ifdef DP1M4_CTRL_PERF_EN
    output logic [CNT_W+7:0]       stall_cnt,
`endif
    output logic [col*psum_bw-1:0] res_data
);

    localparam logic [CNT_W-1:0] W_TERM = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] D_TERM = CNT_W'(drain_lat(col) - 1);

    state_t           state;
    logic [CNT_W-1:0] num_act_q;
    logic [CNT_W-1:0] w_cnt, a_cnt, d_cnt;
    logic             w_at, a_at, d_at;
    logic             start_acc, w_fire, a_fire;
    logic             w_last, a_last, d_last;
    logic             unused_cnt;

    assign busy      = (state != ST_IDLE);
    assign w_ready   = (state == ST_LOAD);
    assign a_ready   = (state == ST_EXEC);
    assign start_acc = (state == ST_IDLE) && start;
    assign w_fire    = w_ready && w_valid;
    assign a_fire    = a_ready && a_valid;

    // Terminal values are "last beat" positions, so counters saturate instead of wrapping.
    assign w_last = w_fire && w_at;
    assign a_last = a_fire && a_at;
    assign d_last = (state == ST_DRAIN) && d_at;

    assign unused_cnt = ^{w_cnt, a_cnt, d_cnt};

    dp1m4_beat_cnt #(.W(CNT_W)) u_w_cnt (
        .clk(clk), .reset(reset), .clr(start_acc), .en(w_fire),
        .term(W_TERM), .cnt(w_cnt), .at_term(w_at)
    );

    dp1m4_beat_cnt #(.W(CNT_W)) u_a_cnt (
        .clk(clk), .reset(reset), .clr(start_acc), .en(a_fire),
        .term(num_act_q - 1'b1), .cnt(a_cnt), .at_term(a_at)
    );

    dp1m4_beat_cnt #(.W(CNT_W)) u_d_cnt (
        .clk(clk), .reset(reset), .clr(start_acc), .en(state == ST_DRAIN),
        .term(D_TERM), .cnt(d_cnt), .at_term(d_at)
    );

`ifdef DP1M4_CTRL_PERF_EN
    logic unused_stall_term;

    dp1m4_beat_cnt #(.W(CNT_W + 8)) u_stall_cnt (
        .clk(clk), .reset(reset), .clr(start_acc),
        .en(((state == ST_LOAD) && !w_valid) || ((state == ST_EXEC) && !a_valid)),
        .term('1), .cnt(stall_cnt), .at_term(unused_stall_term)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state                     <= ST_IDLE;
            num_act_q                 <= '0;
            row_weights_flat          <= '0;
            row_weight_mask           <= '0;
            row_activation_flat       <= '0;
            row_activation_index_flat <= '0;
            row_load                  <= 1'b0;
            row_execute               <= 1'b0;
            row_a_select              <= 1'b0;
            res_valid                 <= 1'b0;
            res_data                  <= '0;
            done                      <= 1'b0;
        end else begin
            done        <= 1'b0;
            row_load    <= 1'b0;
            row_execute <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_act_q <= num_act;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_valid) begin
                        row_weights_flat <= w_data;
                        row_weight_mask  <= w_mask;
                        row_load         <= 1'b1;
                        row_execute      <= 1'b1;
                        if (w_last) begin
                            state <= (num_act_q == '0) ? ST_DRAIN : ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (a_valid) begin
                        row_activation_flat       <= a_data;
                        row_activation_index_flat <= a_idx;
                        row_execute               <= 1'b1;
                        if (a_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (d_last) begin
                        res_data  <= row_psum_flat;
                        res_valid <= 1'b1;
                        state     <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid    <= 1'b0;
                        done         <= 1'b1;
                        row_a_select <= ~row_a_select;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dp1m4_row_ctrl.sv
// Directed self-checking bench for dp1m4_row_ctrl; inputs driven and outputs sampled 1ns after posedge.
module tb_dp1m4_row_ctrl;

    localparam int COL = 4, BW = 4, PSUM_BW = 20, NNZ = 8, TOTAL = 16, CNT_W = 8;

    localparam logic [COL*PSUM_BW-1:0] P1 = 80'h12345_6789A_BCDEF_01234;
    localparam logic [COL*PSUM_BW-1:0] P2 = 80'hFEDCB_A9876_54321_0FEDC;
    localparam logic [COL*PSUM_BW-1:0] P3 = 80'h0AAAA_55555_F0F0F_0C3C3;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic [CNT_W-1:0]       num_act = '0;
    logic                   busy, done;
    logic                   w_valid = 1'b0;
    logic                   w_ready;
    logic [NNZ*BW-1:0]      w_data = '0;
    logic [TOTAL-1:0]       w_mask = '0;
    logic                   a_valid = 1'b0;
    logic                   a_ready;
    logic [2*BW-1:0]        a_data = '0;
    logic [3:0]             a_idx = '0;
    logic [NNZ*BW-1:0]      row_weights_flat;
    logic [TOTAL-1:0]       row_weight_mask;
    logic [2*BW-1:0]        row_activation_flat;
    logic [3:0]             row_activation_index_flat;
    logic                   row_load, row_execute, row_a_select;
    logic [COL*PSUM_BW-1:0] row_psum_flat = '0;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [COL*PSUM_BW-1:0] res_data;
`ifdef DP1M4_CTRL_PERF_EN
    logic [CNT_W+7:0]       stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_load = 0;
    int n_exec = 0;

    dp1m4_row_ctrl #(
        .col(COL), .bw(BW), .psum_bw(PSUM_BW), .nnz(NNZ), .total(TOTAL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_act(num_act),
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_mask(w_mask),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_idx(a_idx),
        .row_weights_flat(row_weights_flat), .row_weight_mask(row_weight_mask),
        .row_activation_flat(row_activation_flat),
        .row_activation_index_flat(row_activation_index_flat),
        .row_load(row_load), .row_execute(row_execute), .row_a_select(row_a_select),
        .row_psum_flat(row_psum_flat), .res_valid(res_valid), .res_ready(res_ready),
`ifdef DP1M4_CTRL_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .res_data(res_data)
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (row_load === 1'b1) n_load++;
        if (row_execute === 1'b1) n_exec++;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        reset = 1'b1; step(); step(); reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_wready", w_ready, 0);
        chk("rst_aready", a_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_asel", row_a_select, 0);
        chk("rst_weights", row_weights_flat, 0);

        // Tile 1: num_act=3, continuous valids
        row_psum_flat = P1;
        start = 1'b1; num_act = 8'd3; step(); start = 1'b0; num_act = 8'd9;
        chk("t1_busy", busy, 1);
        chk("t1_wready", w_ready, 1);
        n_load = 0; n_exec = 0;
        w_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_data = 32'h1111_1111 * (i + 1);
            w_mask = 16'h000F << (4 * i);
            step();
            chk("t1_wdata", row_weights_flat, 32'h1111_1111 * (i + 1));
            chk("t1_rowload", row_load, 1);
        end
        w_valid = 1'b0;
        chk("t1_mask", row_weight_mask, 16'hF000);
        chk("t1_exec_wready", w_ready, 0);
        chk("t1_exec_aready", a_ready, 1);
        n_exec = 0;
        a_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a_data = 8'hA0 + 8'(j);
            a_idx  = 4'(j + 5);
            step();
            chk("t1_exec", row_execute, 1);
            chk("t1_load0", row_load, 0);
            chk("t1_act", row_activation_flat, 8'hA0 + 8'(j));
            chk("t1_idx", row_activation_index_flat, 4'(j + 5));
        end
        a_valid = 1'b0;
        chk("t1_drain_aready", a_ready, 0);
        step();
        chk("t1_drain_exec", row_execute, 0);
        chk("t1_rv_d1", res_valid, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t1_rv_early", res_valid, 0);
        end
        step();
        chk("t1_rv", res_valid, 1);
        chk("t1_rdata", res_data, P1);
        chk("t1_nload", n_load, 4);
        chk("t1_nexec", n_exec, 3);
        res_ready = 1'b1; step();
        chk("t1_done", done, 1);
        chk("t1_rv_clr", res_valid, 0);
        chk("t1_asel", row_a_select, 1);
        chk("t1_busy0", busy, 0);

        // Tile 2: start during done cycle, stalls, held result
        res_ready = 1'b0;
        start = 1'b1; num_act = 8'd3; step(); start = 1'b0;
        chk("t2_done0", done, 0);
        chk("t2_busy", busy, 1);
        chk("t2_wready", w_ready, 1);
        w_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_data = 32'hCAFE_0000 + 32'(i);
            step();
        end
        w_valid = 1'b0;
        chk("t2_wdata", row_weights_flat, 32'hCAFE_0003);
        row_psum_flat = P2;
        a_valid = 1'b1; a_data = 8'h5B; a_idx = 4'h2; step();
        chk("t2_exec_b0", row_execute, 1);
        a_valid = 1'b0; a_data = 8'hEE; a_idx = 4'hF;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t2_stall_exec", row_execute, 0);
            chk("t2_stall_act", row_activation_flat, 8'h5B);
            chk("t2_stall_idx", row_activation_index_flat, 4'h2);
            chk("t2_stall_aready", a_ready, 1);
        end
        a_valid = 1'b1; a_data = 8'h6C; a_idx = 4'h3; step();
        chk("t2_exec_b1", row_execute, 1);
        chk("t2_act_b1", row_activation_flat, 8'h6C);
        a_data = 8'h7D; a_idx = 4'h4; step();
        a_valid = 1'b0;
        chk("t2_drain_aready", a_ready, 0);
`ifdef DP1M4_CTRL_PERF_EN
        chk("t2_stall_cnt", stall_cnt, 2);
`endif
        for (int k = 0; k < 4; k++) step();
        chk("t2_rv_early", res_valid, 0);
        step();
        chk("t2_rv", res_valid, 1);
        chk("t2_rdata", res_data, P2);
        row_psum_flat = P3;
        for (int k = 0; k < 10; k++) begin
            start = (k % 3 == 0);
            step();
            chk("t2_hold_rv", res_valid, 1);
            chk("t2_hold_busy", busy, 1);
            chk("t2_hold_data", res_data, P2);
        end
        start = 1'b0;
        res_ready = 1'b1; step(); res_ready = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_asel", row_a_select, 0);
        step();
        chk("t2_done_pulse", done, 0);
        chk("t2_idle_busy", busy, 0);

        // Tile 3: num_act=0 skips EXEC
        start = 1'b1; num_act = 8'd0; step(); start = 1'b0;
        w_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_data = 32'h0BAD_F00D ^ 32'(i);
            step();
        end
        w_valid = 1'b0;
        chk("t3_wready", w_ready, 0);
        chk("t3_aready", a_ready, 0);
        chk("t3_rowload", row_load, 1);
        n_exec = 0;
        for (int k = 0; k < 4; k++) step();
        chk("t3_rv_early", res_valid, 0);
        step();
        chk("t3_rv", res_valid, 1);
        chk("t3_nexec", n_exec, 0);
        chk("t3_rdata", res_data, P3);
        res_ready = 1'b1; step(); res_ready = 1'b0;
        chk("t3_done", done, 1);
        chk("t3_asel", row_a_select, 1);

        // Tile 4: bubble in LOAD, reset mid-EXEC
        start = 1'b1; num_act = 8'd2; step(); start = 1'b0;
        w_valid = 1'b1; w_data = 32'h1234_5678; w_mask = 16'h00FF; step();
        chk("t4_load", row_load, 1);
        w_valid = 1'b0; w_data = 32'hFFFF_FFFF; step();
        chk("t4_bubble_load", row_load, 0);
        chk("t4_bubble_exec", row_execute, 0);
        chk("t4_bubble_hold", row_weights_flat, 32'h1234_5678);
        w_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_data = 32'h9000_0000 + 32'(i);
            step();
        end
        w_valid = 1'b0;
        a_valid = 1'b1; a_data = 8'hC0; a_idx = 4'h9; step(); a_valid = 1'b0;
        chk("t4_exec", row_execute, 1);
`ifdef DP1M4_CTRL_PERF_EN
        chk("t4_stall_cnt", stall_cnt, 1);
`endif
        reset = 1'b1; step(); reset = 1'b0;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_wready", w_ready, 0);
        chk("t4_rst_aready", a_ready, 0);
        chk("t4_rst_load", row_load, 0);
        chk("t4_rst_exec", row_execute, 0);
        chk("t4_rst_asel", row_a_select, 0);
        chk("t4_rst_rv", res_valid, 0);
        chk("t4_rst_done", done, 0);
        chk("t4_rst_weights", row_weights_flat, 0);
        chk("t4_rst_mask", row_weight_mask, 0);
        chk("t4_rst_act", row_activation_flat, 0);
        chk("t4_rst_idx", row_activation_index_flat, 0);
        chk("t4_rst_rdata", res_data, 0);
`ifdef DP1M4_CTRL_PERF_EN
        chk("t4_rst_stall", stall_cnt, 0);
`endif

        // Tile 5: full tile after reset needs all four weight beats again
        start = 1'b1; num_act = 8'd2; step(); start = 1'b0;
        w_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_data = 32'h5500_0000 + 32'(i);
            step();
        end
        chk("t5_still_load", w_ready, 1);
        chk("t5_no_exec", a_ready, 0);
        w_data = 32'h5500_0003; step(); w_valid = 1'b0;
        chk("t5_exec", a_ready, 1);
        chk("t5_wdata", row_weights_flat, 32'h5500_0003);
        a_valid = 1'b1;
        a_data = 8'h11; a_idx = 4'h1; step();
        a_data = 8'h22; a_idx = 4'h2; step();
        a_valid = 1'b0;
        chk("t5_act", row_activation_flat, 8'h22);
        chk("t5_drain", a_ready, 0);
        for (int k = 0; k < 4; k++) step();
        chk("t5_rv_early", res_valid, 0);
        step();
        chk("t5_rv", res_valid, 1);
        chk("t5_rdata", res_data, P3);
        res_ready = 1'b1; step(); res_ready = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_asel", row_a_select, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
